// File: rtl/rf_plus_alu.sv
// rf_plus_alu: 8 x 16-bit register file with two combinational read ports
// feeding a combinational ADD/ADC/SUB/SBB ALU with Z/N/C/V flags.
module rf_plus_alu (
  input  logic        clk,
  input  logic        clr,
  input  logic [2:0]  Read_Addr_A,
  input  logic [2:0]  Read_Addr_B,
  input  logic [2:0]  Write_Addr,
  input  logic [15:0] Write_Data,
  input  logic        Write_En,
  input  logic        Src_ALU_B,
  input  logic [4:0]  imm5,
  input  logic        Pre_C,
  input  logic        ADC,
  input  logic        SUB,
  input  logic        SBB,
  output logic [15:0] OutA,
  output logic [15:0] OutB,
  output logic [15:0] Y,
  output logic        Z,
  output logic        N,
  output logic        C,
  output logic        V
);

  localparam int NUM_REGS = 8;
  localparam int DW       = 16;

  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic [DW-1:0]               op_a, op_b, b_adj;
  logic                        sub_op, cin;
  logic [DW:0]                 sum;

  // Register file: clr wipes every register immediately and overrides writes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)          regs             <= '0;
    else if (Write_En) regs[Write_Addr] <= Write_Data;
  end

  // Reads are plain muxes; a write only shows up after its clock edge.
  assign OutA = regs[Read_Addr_A];
  assign OutB = regs[Read_Addr_B];

  assign op_a = OutA;
  assign op_b = Src_ALU_B ? {{(DW-5){imm5[4]}}, imm5} : OutB;

  // Operation decode: SBB > SUB > ADC > ADD. Subtraction is A + ~B + cin,
  // so C reads as "no borrow" and Pre_C as "no incoming borrow" for SBB.
  always_comb begin
    sub_op = SBB | SUB;
    cin    = 1'b0;
    if (SBB)      cin = Pre_C;
    else if (SUB) cin = 1'b1;
    else if (ADC) cin = Pre_C;
    b_adj  = sub_op ? ~op_b : op_b;
  end

  // Single 17-bit adder; bit 16 is the carry and never leaks into Y.
  always_comb begin
    sum = {1'b0, op_a} + {1'b0, b_adj} + {{DW{1'b0}}, cin};
    Y   = sum[DW-1:0];
    C   = sum[DW];
    Z   = (sum[DW-1:0] == '0);
    N   = sum[DW-1];
    V   = (op_a[DW-1] == b_adj[DW-1]) && (sum[DW-1] != op_a[DW-1]);
  end

endmodule

// File: tb/tb_rf_plus_alu.sv
// tb_rf_plus_alu: directed register-file/ALU cases followed by random
// writes and operations checked against an arithmetic reference model.
module tb_rf_plus_alu;

  logic        clk = 1'b0;
  logic        clr;
  logic [2:0]  Read_Addr_A, Read_Addr_B, Write_Addr;
  logic [15:0] Write_Data;
  logic        Write_En, Src_ALU_B, Pre_C, ADC, SUB, SBB;
  logic [4:0]  imm5;
  logic [15:0] OutA, OutB, Y;
  logic        Z, N, C, V;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mdl [8];

  rf_plus_alu dut (
    .clk(clk), .clr(clr),
    .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
    .Write_Addr(Write_Addr), .Write_Data(Write_Data), .Write_En(Write_En),
    .Src_ALU_B(Src_ALU_B), .imm5(imm5), .Pre_C(Pre_C),
    .ADC(ADC), .SUB(SUB), .SBB(SBB),
    .OutA(OutA), .OutB(OutB), .Y(Y), .Z(Z), .N(N), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: true integer arithmetic, returns {Y,Z,N,C,V}.
  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic pc, input logic adc,
                                          input logic sub, input logic sbb);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [15:0] y;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    if (sbb) begin
      r = ua - ub - (pc ? 0 : 1); sr = sa - sb - (pc ? 0 : 1); c = (r >= 0);
    end else if (sub) begin
      r = ua - ub; sr = sa - sb; c = (r >= 0);
    end else if (adc) begin
      r = ua + ub + (pc ? 1 : 0); sr = sa + sb + (pc ? 1 : 0); c = (r > 65535);
    end else begin
      r = ua + ub; sr = sa + sb; c = (r > 65535);
    end
    y = r[15:0];
    v = (sr > 32767) || (sr < -32768);
    return {y, (y == 16'h0), y[15], c, v};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic en);
    @(negedge clk);
    Write_Addr = a; Write_Data = d; Write_En = en;
    @(posedge clk);
    if (en) mdl[a] = d;
    #1 Write_En = 1'b0;
  endtask

  task automatic op(input logic [2:0] ra, input logic [2:0] rb, input logic src,
                    input logic [4:0] im, input logic pc, input logic a,
                    input logic s, input logic sb);
    logic [15:0] bexp;
    int si;
    @(negedge clk);
    Read_Addr_A = ra; Read_Addr_B = rb; Src_ALU_B = src; imm5 = im;
    Pre_C = pc; ADC = a; SUB = s; SBB = sb;
    #1;
    si   = $signed(im);
    bexp = src ? si[15:0] : mdl[rb];
    chk("outa", {16'h0, OutA}, {16'h0, mdl[ra]});
    chk("outb", {16'h0, OutB}, {16'h0, mdl[rb]});
    chk("alu_yznvc", {12'h0, Y, Z, N, C, V}, {12'h0, ref_alu(mdl[ra], bexp, pc, a, s, sb)});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    clr = 1'b0; Read_Addr_A = 0; Read_Addr_B = 0; Write_Addr = 0; Write_Data = 0;
    Write_En = 0; Src_ALU_B = 0; imm5 = 0; Pre_C = 0; ADC = 0; SUB = 0; SBB = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outa", {16'h0, OutA}, 32'h0);
    chk("rst_outb", {16'h0, OutB}, 32'h0);
    chk("rst_flags", {12'h0, Y, Z, N, C, V}, {12'h0, 16'h0, 4'b1000});
    @(negedge clk) clr = 1'b1;

    wr(0, 16'h1234, 1);
    wr(1, 16'h2345, 1);
    op(0, 1, 0, 0, 0, 0, 0, 0);
    chk("add_y", {16'h0, Y}, 32'h3579);
    chk("add_f", {28'h0, Z, N, C, V}, 32'h0);
    op(0, 1, 0, 0, 0, 1, 0, 0);  chk("adc0_y", {16'h0, Y}, 32'h3579);
    op(0, 1, 0, 0, 1, 1, 0, 0);  chk("adc1_y", {16'h0, Y}, 32'h357A);
    chk("adc1_c", {31'h0, C}, 32'h0);
    op(0, 1, 0, 0, 0, 0, 1, 0);  chk("sub_yf", {12'h0, Y, N, C, V}, {12'h0, 16'hEEEF, 3'b100});
    op(0, 1, 0, 0, 1, 0, 1, 0);  chk("sub_pc1", {16'h0, Y}, 32'hEEEF);
    op(0, 1, 0, 0, 0, 0, 0, 1);  chk("sbb0_y", {16'h0, Y}, 32'hEEEE);
    op(0, 1, 0, 0, 1, 0, 0, 1);  chk("sbb1_y", {16'h0, Y}, 32'hEEEF);
    chk("sbb1_c", {31'h0, C}, 32'h0);
    op(0, 1, 0, 0, 1, 1, 1, 1);  chk("prio_sbb", {16'h0, Y}, 32'hEEEF);
    op(0, 1, 1, 5'b11111, 0, 0, 0, 0);
    chk("imm_neg", {15'h0, Y, C}, {15'h0, 16'h1233, 1'b1});
    op(0, 1, 1, 5'b01111, 0, 0, 0, 0);
    chk("imm_pos", {15'h0, Y, C}, {15'h0, 16'h1243, 1'b0});

    wr(2, 16'h7FFF, 1); wr(3, 16'h0001, 1); wr(4, 16'hFFFF, 1); wr(5, 16'h8000, 1);
    op(2, 3, 0, 0, 0, 0, 0, 0);
    chk("ovf_add", {12'h0, Y, N, V}, {12'h0, 16'h8000, 2'b11});
    op(4, 3, 0, 0, 0, 0, 0, 0);
    chk("zero_add", {12'h0, Y, Z, C, V}, {12'h0, 16'h0000, 3'b110});
    op(5, 3, 0, 0, 0, 0, 1, 0);
    chk("ovf_sub", {12'h0, Y, C, V}, {12'h0, 16'h7FFF, 2'b11});

    // Write with enable low leaves the register alone.
    wr(0, 16'hABCD, 0);
    op(0, 1, 0, 0, 0, 0, 0, 0);
    chk("we0_r0", {16'h0, OutA}, 32'h1234);

    // New data is not visible before the write edge.
    @(negedge clk);
    Write_Addr = 6; Write_Data = 16'h5A5A; Write_En = 1; Read_Addr_A = 6;
    #1 chk("pre_edge", {16'h0, OutA}, 32'h0);
    @(posedge clk); mdl[6] = 16'h5A5A;
    #1 chk("post_edge", {16'h0, OutA}, 32'h5A5A);
    Write_En = 0;

    // Asynchronous clear mid-cycle, with a write attempted during reset.
    @(negedge clk);
    Read_Addr_A = 0; Read_Addr_B = 1; Src_ALU_B = 0; ADC = 0; SUB = 0; SBB = 0;
    #2 clr = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    #1;
    chk("clr_outa", {16'h0, OutA}, 32'h0);
    chk("clr_outb", {16'h0, OutB}, 32'h0);
    chk("clr_flags", {12'h0, Y, Z, N, C, V}, {12'h0, 16'h0, 4'b1000});
    Write_Addr = 2; Write_Data = 16'hFFFF; Write_En = 1;
    @(posedge clk); #1;
    Read_Addr_A = 2;
    #1 chk("clr_blocks_wr", {16'h0, OutA}, 32'h0);
    Write_En = 0;
    @(negedge clk) clr = 1'b1;
    for (int i = 0; i < 8; i++) op(3'(i), 3'(7 - i), 0, 0, 0, 0, 0, 0);

    // Random mix of writes and operations.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0)
        wr(3'($urandom), 16'($urandom), 1'($urandom));
      else
        op(3'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_plus_alu.md
RF_PLUS_ALU -- requirements
Module: rf_plus_alu

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, named clk and clr as the codebase does.
REQ-002 clk  in  1  clock; all register-file writes occur on its rising edge.
REQ-003 clr  in  1  asynchronous active-low reset; 0 clears the register file.
REQ-004 Read_Addr_A  in  3  register index driving OutA.
REQ-005 Read_Addr_B  in  3  register index driving OutB.
REQ-006 Write_Addr  in  3  register index for write.
REQ-007 Write_Data  in  16  data to write.
REQ-008 Write_En  in  1  write enable, active high.
REQ-009 Src_ALU_B  in  1  ALU B select: 0 = OutB, 1 = sign-extended imm5.
REQ-010 imm5  in  5  immediate operand.
REQ-011 Pre_C  in  1  incoming carry for ADC/SBB.
REQ-012 ADC, SUB, SBB  in  1 each  operation selects; all low = ADD.
REQ-013 OutA, OutB  out  16  register read data.
REQ-014 Y  out  16  ALU result.
REQ-015 Z, N, C, V  out  1 each  zero, negative, carry, overflow flags.

Function
REQ-016 Register file: 8 x 16-bit registers; R0 is an ordinary writable register.
REQ-017 Write: on rising clk, if Write_En=1 and clr=1, reg[Write_Addr] <= Write_Data.
REQ-018 Reads are combinational: OutA = reg[Read_Addr_A], OutB = reg[Read_Addr_B]; no write-to-read bypass; new data appears after the write edge.
REQ-019 Operand A = OutA; operand B = Src_ALU_B ? {11{imm5[4]}, imm5} : OutB.
REQ-020 Op priority SBB > SUB > ADC > ADD.
REQ-021 ADD: {C,Y} = A + B.
REQ-022 ADC: {C,Y} = A + B + Pre_C.
REQ-023 SUB: {C,Y} = A + ~B + 1; C = 1 means no borrow.
REQ-024 SBB: {C,Y} = A + ~B + Pre_C; Pre_C = 1 means no incoming borrow.
REQ-025 The ALU and flags SHALL be purely combinational, with zero-cycle latency from any input or register change; the block has no flag register.
REQ-026 Z = (Y == 0); N = Y[15]; C = bit 16 of the 17-bit sum.
REQ-027 V = (A[15] == Badj[15]) and (Y[15] != A[15]), where Badj = B for ADD/ADC and ~B for SUB/SBB.
REQ-028 All arithmetic wraps modulo 2^16; the carry-out goes only to C.

Reset
REQ-029 clr = 0 SHALL asynchronously clear all 8 registers to 0000, taking priority over any write in the same cycle.
REQ-030 During reset, OutA = OutB = 0000; Y and flags follow combinationally (ADD with Src_ALU_B = 0 gives Y = 0000, Z = 1, N = C = V = 0).
REQ-031 On clr rising, the block operates from the next clk edge; a write pending at release is accepted only on a later rising edge with clr = 1.

Verification
REQ-032 Write R0 = 1234 and R1 = 2345; read A = R0, B = R1, ADD -> Y = 3579, Z = N = C = V = 0.
REQ-033 Same operands, ADC: Pre_C = 0 -> Y = 3579; Pre_C = 1 -> Y = 357A, C = 0.
REQ-034 Same operands, SUB: Y = EEEF, N = 1, C = 0, V = 0, independent of Pre_C; SBB: Pre_C = 0 -> Y = EEEE, Pre_C = 1 -> Y = EEEF, C = 0.
REQ-035 R0 = 1234, Src_ALU_B = 1, imm5 = 11111, ADD -> B = FFFF, Y = 1233, C = 1; with imm5 = 01111 -> Y = 1243, C = 0.
REQ-036 Overflow and zero: 7FFF + 0001 -> Y = 8000, V = 1, N = 1; FFFF + 0001 -> Y = 0000, Z = 1, C = 1, V = 0; 8000 SUB 0001 -> 7FFF, V = 1, C = 1.
REQ-037 Reset and write timing: pulse clr = 0 mid-run -> all registers read 0000 immediately, without a clock edge; a write with Write_En = 0 leaves the register unchanged; a written value is not visible on OutA before the write edge.
